// File: rtl/wb_ddr2_arbiter_if.sv
// Bus bundle between NUM_MASTERS Wishbone masters, the round-robin arbiter and
// the single DDR2 Wishbone slave port.
//   m_*_i / m_*_o : packed per-master request and response signals
//                   (master k occupies slice k of each packed vector)
//   m_dat_o       : read data broadcast to every master
//   s_*_o / s_*_i : the one muxed transfer presented to the DDR2 slave
// Modports:
//   slave  : the arbiter's view (it is the slave of every master request and
//            drives the DDR2 side on their behalf)
//   master : the surrounding system's view (masters and the DDR2 slave)
interface wb_ddr2_arbiter_if #(
  parameter int NUM_MASTERS = 4
) ();
  logic [NUM_MASTERS*32-1:0] m_adr_i;
  logic [NUM_MASTERS*32-1:0] m_dat_i;
  logic [NUM_MASTERS*4-1:0]  m_sel_i;
  logic [NUM_MASTERS*3-1:0]  m_cti_i;
  logic [NUM_MASTERS*2-1:0]  m_bte_i;
  logic [NUM_MASTERS-1:0]    m_cyc_i;
  logic [NUM_MASTERS-1:0]    m_stb_i;
  logic [NUM_MASTERS-1:0]    m_we_i;
  logic [NUM_MASTERS-1:0]    m_ack_o;
  logic [NUM_MASTERS-1:0]    m_err_o;
  logic [NUM_MASTERS-1:0]    m_rty_o;
  logic [31:0]               m_dat_o;

  logic [31:0] s_adr_o;
  logic [31:0] s_dat_o;
  logic [3:0]  s_sel_o;
  logic [2:0]  s_cti_o;
  logic [1:0]  s_bte_o;
  logic        s_cyc_o;
  logic        s_stb_o;
  logic        s_we_o;
  logic        s_ack_i;
  logic        s_err_i;
  logic        s_rty_i;
  logic [31:0] s_dat_i;

  modport slave (
    input  m_adr_i, m_dat_i, m_sel_i, m_cti_i, m_bte_i, m_cyc_i, m_stb_i, m_we_i,
    output m_ack_o, m_err_o, m_rty_o, m_dat_o,
    output s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_bte_o, s_cyc_o, s_stb_o, s_we_o,
    input  s_ack_i, s_err_i, s_rty_i, s_dat_i
  );

  modport master (
    output m_adr_i, m_dat_i, m_sel_i, m_cti_i, m_bte_i, m_cyc_i, m_stb_i, m_we_i,
    input  m_ack_o, m_err_o, m_rty_o, m_dat_o,
    input  s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_bte_o, s_cyc_o, s_stb_o, s_we_o,
    output s_ack_i, s_err_i, s_rty_i, s_dat_i
  );
endinterface

// File: rtl/wb_ddr2_arbiter.sv
// Round-robin Wishbone arbiter in front of the DDR2 controller wrapper.
// A grant is held for the whole bus cycle (cyc high) so bursts are never
// split; no grant is issued before DDR2 calibration completes; a watchdog
// aborts a stalled transfer with an error to the owning master.
// Ports:
//   wb_clk              : Wishbone / DDR2 UI clock
//   wb_rst              : asynchronous active-high reset
//   init_calib_complete : DDR2 calibration done, gates new grants
//   grant_o             : one-hot current grant, zero when idle
//   bus                 : master-side and slave-side Wishbone signals
//
// state | meaning
// IDLE  | no owner; arbitrate among cyc requesters once calibrated
// BUSY  | owner's signals muxed to the slave, responses routed back
// ABORT | watchdog fired; slave transfer dropped, wait for owner to drop cyc
module wb_ddr2_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int TIMEOUT     = 1023,
  parameter int TO_WIDTH    = 10
) (
  input  logic                   wb_clk,
  input  logic                   wb_rst,
  input  logic                   init_calib_complete,
  output logic [NUM_MASTERS-1:0] grant_o,
  wb_ddr2_arbiter_if.slave       bus
);

  localparam int IDX_W = $clog2(NUM_MASTERS);

  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       gidx_q, gidx_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [TO_WIDTH-1:0]    wd_cnt_q, wd_cnt_d;
  logic                   err_pend_q, err_pend_d;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic             wd_hit;
  logic             resp;

  logic        g_cyc, g_stb, g_we;
  logic [31:0] g_adr, g_dat;
  logic [3:0]  g_sel;
  logic [2:0]  g_cti;
  logic [1:0]  g_bte;

  assign resp        = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;
  assign grant_o     = grant_q;
  assign bus.m_dat_o = bus.s_dat_i;

  // State register
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      rr_ptr_q   <= IDX_W'(NUM_MASTERS - 1);
      wd_cnt_q   <= '0;
      err_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      rr_ptr_q   <= rr_ptr_d;
      wd_cnt_q   <= wd_cnt_d;
      err_pend_q <= err_pend_d;
    end
  end

  // Round-robin search: first requester strictly after the last winner.
  always_comb begin
    int cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand = (int'(rr_ptr_q) + i) % NUM_MASTERS;
      if (!win_found && bus.m_cyc_i[cand]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  // Granted master's request signals.
  always_comb begin
    g_cyc = 1'b0;
    g_stb = 1'b0;
    g_we  = 1'b0;
    g_adr = '0;
    g_dat = '0;
    g_sel = '0;
    g_cti = '0;
    g_bte = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (gidx_q == IDX_W'(k)) begin
        g_cyc = bus.m_cyc_i[k];
        g_stb = bus.m_stb_i[k];
        g_we  = bus.m_we_i[k];
        g_adr = bus.m_adr_i[k*32 +: 32];
        g_dat = bus.m_dat_i[k*32 +: 32];
        g_sel = bus.m_sel_i[k*4 +: 4];
        g_cti = bus.m_cti_i[k*3 +: 3];
        g_bte = bus.m_bte_i[k*2 +: 2];
      end
    end
  end

  // Watchdog: counts consecutive stalled strobe cycles; fires on the cycle
  // the count reaches TIMEOUT so the abort takes effect on the next edge.
  always_comb begin
    wd_cnt_d = '0;
    wd_hit   = 1'b0;
    if (TIMEOUT > 0 && state_q == BUSY && g_cyc && g_stb && !resp) begin
      wd_cnt_d = wd_cnt_q + TO_WIDTH'(1);
      wd_hit   = (wd_cnt_d == TO_WIDTH'(TIMEOUT));
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (init_calib_complete && win_found) state_d = BUSY;
      BUSY: begin
        if (!g_cyc)      state_d = IDLE;
        else if (wd_hit) state_d = ABORT;
      end
      ABORT:   if (!g_cyc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant bookkeeping
  always_comb begin
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    rr_ptr_d   = rr_ptr_q;
    err_pend_d = (state_q == BUSY) && (state_d == ABORT);
    if (state_q == IDLE && state_d == BUSY) begin
      gidx_d   = win_idx;
      rr_ptr_d = win_idx;
      grant_d  = NUM_MASTERS'(1) << win_idx;
    end
    if (state_d == IDLE) grant_d = '0;
  end

  // Output logic
  always_comb begin
    bus.s_adr_o = g_adr;
    bus.s_dat_o = g_dat;
    bus.s_sel_o = g_sel;
    bus.s_cti_o = g_cti;
    bus.s_bte_o = g_bte;
    bus.s_cyc_o = 1'b0;
    bus.s_stb_o = 1'b0;
    bus.s_we_o  = 1'b0;
    bus.m_ack_o = '0;
    bus.m_err_o = '0;
    bus.m_rty_o = '0;
    case (state_q)
      BUSY: begin
        bus.s_cyc_o = g_cyc;
        bus.s_stb_o = g_cyc & g_stb;
        bus.s_we_o  = g_we;
        bus.m_ack_o = grant_q & {NUM_MASTERS{bus.s_ack_i}};
        bus.m_err_o = grant_q & {NUM_MASTERS{bus.s_err_i}};
        bus.m_rty_o = grant_q & {NUM_MASTERS{bus.s_rty_i}};
      end
      ABORT:   bus.m_err_o = grant_q & {NUM_MASTERS{err_pend_q}};
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_ddr2_arbiter.sv
module tb_wb_ddr2_arbiter;
  localparam int N  = 4;
  localparam int TO = 15;

  logic         wb_clk = 1'b0;
  logic         wb_rst = 1'b0;
  logic         calib  = 1'b0;
  logic [N-1:0] grant_o;

  wb_ddr2_arbiter_if #(.NUM_MASTERS(N)) bus ();

  wb_ddr2_arbiter #(.NUM_MASTERS(N), .TIMEOUT(TO), .TO_WIDTH(10)) dut (
    .wb_clk              (wb_clk),
    .wb_rst              (wb_rst),
    .init_calib_complete (calib),
    .grant_o             (grant_o),
    .bus                 (bus)
  );

  always #5 wb_clk = ~wb_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int last_win = N - 1;
  logic [N-1:0] req = '0;

  logic [31:0] base_of [N];
  logic [31:0] dat_of  [N];
  logic [31:0] rd_of   [N];
  logic [3:0]  sel_of  [N];
  bit          we_of   [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  // Reference: first requester after the last winner, wrapping around.
  function automatic int rr_winner(input logic [N-1:0] r, input int last);
    for (int i = 1; i <= N; i++)
      if (r[(last + i) % N]) return (last + i) % N;
    return -1;
  endfunction

  task automatic set_m(input int m, input bit cyc, input bit stb, input bit we,
                       input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic [2:0] cti);
    bus.m_cyc_i[m]          = cyc;
    bus.m_stb_i[m]          = stb;
    bus.m_we_i[m]           = we;
    bus.m_adr_i[m*32 +: 32] = adr;
    bus.m_dat_i[m*32 +: 32] = dat;
    bus.m_sel_i[m*4 +: 4]   = sel;
    bus.m_cti_i[m*3 +: 3]   = cti;
    bus.m_bte_i[m*2 +: 2]   = 2'(m);
    req[m]                  = cyc;
  endtask

  task automatic cfg(input int m, input bit we, input logic [31:0] adr,
                     input logic [31:0] dat, input logic [31:0] rd, input logic [3:0] sel);
    we_of[m] = we; base_of[m] = adr; dat_of[m] = dat; rd_of[m] = rd; sel_of[m] = sel;
    set_m(m, 1'b1, 1'b1, we, adr, dat, sel, 3'b000);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_grant"}, grant_o, 0);
    chk({tag, "_s_cyc"}, bus.s_cyc_o, 0);
    chk({tag, "_s_stb"}, bus.s_stb_o, 0);
    chk({tag, "_s_we"},  bus.s_we_o, 0);
    chk({tag, "_m_ack"}, bus.m_ack_o, 0);
    chk({tag, "_m_err"}, bus.m_err_o, 0);
    chk({tag, "_m_rty"}, bus.m_rty_o, 0);
  endtask

  task automatic do_reset();
    wb_rst = 1'b1;
    bus.m_adr_i = '0; bus.m_dat_i = '0; bus.m_sel_i = '0; bus.m_cti_i = '0;
    bus.m_bte_i = '0; bus.m_cyc_i = '0; bus.m_stb_i = '0; bus.m_we_i = '0;
    bus.s_ack_i = 1'b0; bus.s_err_i = 1'b0; bus.s_rty_i = 1'b0; bus.s_dat_i = 32'h0;
    req = '0;
    #1;
    check_idle_outputs("reset");
    tick();
    tick();
    wb_rst   = 1'b0;
    last_win = N - 1;
  endtask

  task automatic wait_grant(output int who);
    int exp;
    int t;
    exp = rr_winner(req, last_win);
    t   = 0;
    do begin
      tick();
      t++;
    end while (grant_o == '0 && t < 6);
    chk("grant_latency", t, 1);
    chk("grant", grant_o, (exp < 0) ? 0 : (1 << exp));
    if (exp >= 0) last_win = exp;
    who = exp;
  endtask

  // Serves nbeats transfers of the granted master m; kind 0=ack 1=err 2=rty.
  task automatic serve(input int m, input int nbeats, input int delay,
                       input int kind, input bit rereq);
    logic [2:0]  cti;
    logic [31:0] adr;
    for (int b = 0; b < nbeats; b++) begin
      cti = (nbeats == 1) ? 3'b000 : ((b == nbeats - 1) ? 3'b111 : 3'b010);
      adr = base_of[m] + 32'(4 * b);
      set_m(m, 1'b1, 1'b1, we_of[m], adr, dat_of[m] + 32'(b), sel_of[m], cti);
      #1;
      chk("s_cyc", bus.s_cyc_o, 1);
      chk("s_stb", bus.s_stb_o, 1);
      chk("s_adr", bus.s_adr_o, adr);
      chk("s_sel", bus.s_sel_o, sel_of[m]);
      chk("s_we",  bus.s_we_o, we_of[m]);
      chk("s_cti", bus.s_cti_o, cti);
      chk("s_bte", bus.s_bte_o, m % 4);
      if (we_of[m]) chk("s_dat", bus.s_dat_o, dat_of[m] + 32'(b));
      repeat (delay) begin
        tick();
        chk("grant_hold", grant_o, 1 << m);
        chk("ack_wait", bus.m_ack_o, 0);
      end
      bus.s_ack_i = (kind == 0);
      bus.s_err_i = (kind == 1);
      bus.s_rty_i = (kind == 2);
      bus.s_dat_i = rd_of[m] + 32'(b);
      #1;
      chk("m_ack", bus.m_ack_o, (kind == 0) ? (1 << m) : 0);
      chk("m_err", bus.m_err_o, (kind == 1) ? (1 << m) : 0);
      chk("m_rty", bus.m_rty_o, (kind == 2) ? (1 << m) : 0);
      if (!we_of[m]) chk("m_dat", bus.m_dat_o, rd_of[m] + 32'(b));
      tick();
      bus.s_ack_i = 1'b0; bus.s_err_i = 1'b0; bus.s_rty_i = 1'b0;
    end
    set_m(m, 1'b0, 1'b0, we_of[m], base_of[m], dat_of[m], sel_of[m], 3'b000);
    #1;
    chk("s_cyc_drop", bus.s_cyc_o, 0);
    tick();
    chk("grant_clear", grant_o, 0);
    if (rereq) set_m(m, 1'b1, 1'b1, we_of[m], base_of[m], dat_of[m], sel_of[m], 3'b000);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int w;
    logic [N-1:0] mask;
    #2;
    // Calibration gate
    calib = 1'b0;
    do_reset();
    cfg(0, 1'b0, 32'h40, 32'h0, 32'hA5A5_0000, 4'hF);
    repeat (20) begin
      tick();
      chk("calib_grant_blocked", grant_o, 0);
      chk("calib_s_cyc_blocked", bus.s_cyc_o, 0);
    end
    calib = 1'b1;
    #1;
    chk("calib_rise_same_cycle", grant_o, 0);
    wait_grant(w);
    serve(0, 1, 0, 0, 1'b0);

    // Masters 0 and 2, single reads, ack 3 cycles after stb
    do_reset();
    cfg(0, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 4'hF);
    cfg(2, 1'b0, 32'h200, 32'h0, 32'h1234_5678, 4'hF);
    wait_grant(w); serve(w, 1, 3, 0, 1'b0);
    wait_grant(w); serve(w, 1, 3, 0, 1'b0);
    cfg(0, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 4'hF);
    cfg(2, 1'b0, 32'h200, 32'h0, 32'h1234_5678, 4'hF);
    wait_grant(w); serve(w, 1, 3, 0, 1'b0);
    wait_grant(w); serve(w, 1, 3, 0, 1'b0);

    // All four masters keep requesting with single writes
    do_reset();
    for (int k = 0; k < N; k++)
      cfg(k, 1'b1, 32'h1000 * (k + 1), 32'hC0DE_0000 + k, 32'h0, 4'(1 << k));
    repeat (5) begin
      wait_grant(w);
      serve(w, 1, 1, 0, 1'b1);
    end

    // 8-beat incrementing burst on master 1 while master 3 waits
    do_reset();
    cfg(1, 1'b0, 32'h3000, 32'h0, 32'h5000_0000, 4'hF);
    cfg(3, 1'b1, 32'h3F00, 32'h7777_0003, 32'h0, 4'h3);
    wait_grant(w); serve(w, 8, 1, 0, 1'b0);
    wait_grant(w); serve(w, 1, 2, 0, 1'b0);

    // Watchdog abort on master 0
    do_reset();
    cfg(0, 1'b0, 32'h500, 32'h0, 32'h0, 4'hF);
    wait_grant(w);
    chk("wd_stb", bus.s_stb_o, 1);
    for (int i = 1; i < TO; i++) begin
      tick();
      chk("wd_no_err", bus.m_err_o, 0);
      chk("wd_cyc_held", bus.s_cyc_o, 1);
    end
    tick();
    chk("wd_err", bus.m_err_o, 4'b0001);
    chk("wd_s_cyc", bus.s_cyc_o, 0);
    chk("wd_s_stb", bus.s_stb_o, 0);
    chk("wd_grant", grant_o, 4'b0001);
    bus.s_ack_i = 1'b1;
    #1;
    chk("late_ack", bus.m_ack_o, 0);
    tick();
    chk("err_once", bus.m_err_o, 0);
    chk("abort_grant", grant_o, 4'b0001);
    chk("abort_s_cyc", bus.s_cyc_o, 0);
    bus.s_ack_i = 1'b0;
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h500, 32'h0, 4'hF, 3'b000);
    tick();
    chk("abort_exit", grant_o, 0);

    // Reset in the second beat of a burst
    do_reset();
    cfg(1, 1'b0, 32'h6000, 32'h0, 32'h6600_0000, 4'hF);
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h6000, 32'h0, 4'hF, 3'b010);
    wait_grant(w);
    bus.s_ack_i = 1'b1;
    tick();
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h6004, 32'h0, 4'hF, 3'b010);
    #1;
    chk("beat2_ack", bus.m_ack_o, 4'b0010);
    wb_rst = 1'b1;
    #1;
    chk("rst_grant", grant_o, 0);
    chk("rst_s_cyc", bus.s_cyc_o, 0);
    chk("rst_m_ack", bus.m_ack_o, 0);
    chk("rst_s_stb", bus.s_stb_o, 0);
    bus.s_ack_i = 1'b0;
    tick();
    tick();
    wb_rst   = 1'b0;
    last_win = N - 1;
    cfg(0, 1'b1, 32'h0700, 32'h0BAD_F00D, 32'h0, 4'h1);
    wait_grant(w); serve(w, 1, 0, 0, 1'b0);
    wait_grant(w); serve(w, 1, 1, 0, 1'b0);

    // Randomized request sets against the round-robin reference
    do_reset();
    for (int r = 0; r < 16; r++) begin
      mask = 4'($urandom_range(1, (1 << N) - 1));
      for (int k = 0; k < N; k++)
        if (mask[k])
          cfg(k, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom,
              $urandom, 4'($urandom_range(1, 15)));
      for (int j = 0; j < N && req != '0; j++) begin
        wait_grant(w);
        if (w < 0) break;
        serve(w, $urandom_range(1, 3), $urandom_range(0, 3),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0, 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_ddr2_arbiter.md
Name: wb_ddr2_arbiter

Overview:
- Round-robin Wishbone arbiter that shares the single Wishbone slave port of the DDR2 controller wrapper among NUM_MASTERS masters.
- Holds a grant for the master's whole bus cycle (cyc high), so classic and incrementing bursts are never split.
- Blocks all grants until DDR2 calibration completes.
- A watchdog terminates a stalled cycle with an error to the master.

Parameters:
NUM_MASTERS, 4, number of Wishbone masters (2..8)
TIMEOUT, 1023, cycles with slave stb high and no ack/err/rty before abort; 0 disables the watchdog
TO_WIDTH, 10, watchdog counter width; must satisfy 2^TO_WIDTH > TIMEOUT

Ports:
wb_clk  in  1  Wishbone clock (the DDR2 controller UI clock)
wb_rst  in  1  reset, asynchronous, active-high
init_calib_complete  in  1  DDR2 calibration done; no grant is issued while low
m_adr_i  in  NUM_MASTERS*32  packed master addresses; master k occupies bits [32k+31:32k]
m_dat_i  in  NUM_MASTERS*32  packed master write data
m_sel_i  in  NUM_MASTERS*4  packed byte selects
m_cti_i  in  NUM_MASTERS*3  packed cycle type identifiers
m_bte_i  in  NUM_MASTERS*2  packed burst type extensions
m_cyc_i  in  NUM_MASTERS  per-master cyc
m_stb_i  in  NUM_MASTERS  per-master stb
m_we_i  in  NUM_MASTERS  per-master we
m_ack_o  out  NUM_MASTERS  per-master ack
m_err_o  out  NUM_MASTERS  per-master err
m_rty_o  out  NUM_MASTERS  per-master rty
m_dat_o  out  32  read data, broadcast to all masters
s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_bte_o  out  32/32/4/3/2  muxed to the DDR2 slave
s_cyc_o, s_stb_o, s_we_o  out  1  muxed to the DDR2 slave
s_ack_i, s_err_i, s_rty_i  in  1  slave responses
s_dat_i  in  32  slave read data
grant_o  out  NUM_MASTERS  one-hot current grant; all-zero when idle

Behaviour:
- Reset values (async assert): state=IDLE, grant_o=0, rr pointer=NUM_MASTERS-1, watchdog counter=0.
  - All m_ack_o/m_err_o/m_rty_o=0; s_cyc_o=s_stb_o=s_we_o=0.
  - m_dat_o is a passthrough of s_dat_i.
- States: IDLE, BUSY, ABORT.
- IDLE:
  - If init_calib_complete=1 and any m_cyc_i bit is set, register a one-hot grant and go to BUSY.
  - Winner: first set m_cyc_i bit searching upward from rr_ptr+1, modulo NUM_MASTERS.
  - Grant appears one cycle after cyc is sampled, so arbitration latency is 1 cycle.
  - rr_ptr updates to the winner index.
- BUSY:
  - Slave outputs are combinational muxes of the granted master's signals.
  - s_cyc_o = m_cyc_i[g]; s_stb_o = m_cyc_i[g] & m_stb_i[g].
  - s_ack_i/s_err_i/s_rty_i route only to master g. Other masters see 0.
  - When m_cyc_i[g] falls, go to IDLE. grant_o clears on the next edge.
  - No re-arbitration occurs mid-cycle, including across bursts (cti=010 through 111).
- Back-to-back: in the cycle after return to IDLE, all requesters are eligible; the last winner has lowest priority.
- Watchdog (TIMEOUT>0):
  - In BUSY, the counter increments each cycle s_stb_o=1 and s_ack_i|s_err_i|s_rty_i=0.
  - It clears on any response or when stb is low.
  - When counter==TIMEOUT, go to ABORT.
- ABORT:
  - s_cyc_o=s_stb_o=0 (the slave transfer is dropped).
  - m_err_o[g]=1 for exactly one cycle, the first ABORT cycle.
  - Remain in ABORT until m_cyc_i[g]=0, then go to IDLE.
  - Late slave responses arriving in ABORT are discarded.
- init_calib_complete falling while in BUSY: the current cycle completes normally and no new grant is issued.
- A master dropping cyc without having received ack: legal; the arbiter returns to IDLE.
- Simultaneous slave ack and m_cyc_i[g] falling: the ack is routed and the state goes to IDLE.
- Reset asserted mid-cycle: all outputs immediately return to reset values. The slave sees cyc drop asynchronously.

Test Plan:
- init_calib_complete=0, m_cyc_i=4'b0001 for 20 cycles, then calib=1 -> grant_o stays 0 and s_cyc_o stays 0; grant_o=0001 one cycle after calib rises.
- Masters 0 and 2 request at once, single reads of 0x100 and 0x200, with slave ack 3 cycles after stb -> master 0 completes with data 0xDEADBEEF, then master 2 is granted; on the next joint request master 2 loses to master 0.
- All 4 masters hold cyc continuously with single writes -> grant order is 0,1,2,3,0; each m_ack_o pulses only on its owner; s_sel_o/s_adr_o match the owner.
- Master 1 issues an 8-beat incrementing burst (cti=010 then 111) while master 3 requests -> 8 acks to master 1 with no grant change; master 3 is granted only after master 1 drops cyc.
- TIMEOUT=15, slave never acks master 0's read -> m_err_o[0] pulses once 15 cycles after stb; s_cyc_o drops; a late s_ack_i is not forwarded; IDLE after master 0 drops cyc.
- wb_rst asserted in the 2nd beat of a burst -> grant_o=0, s_cyc_o=0 and m_ack_o=0 immediately (asynchronously); the first grant after release follows rr_ptr=NUM_MASTERS-1, so master 0 wins.
